// File: rtl/miner_nonce_sched.sv
// miner_nonce_sched
// Nonce-search sequencer for Bitcoin-style double SHA-256. For every nonce in
// [start .. end] (inclusive, wrapping through 0xFFFFFFFF) it drives a
// sha256_core-style engine with three blocks:
//   B1 = header[607:96]                         (init)
//   B2 = header tail, nonce (LE), padding       (next)
//   B3 = first digest, padding                  (init)
// It then byte-reverses the final digest and compares it against the target.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   job_*               job handshake (job_ready high only in IDLE) and job fields
//   abort               cancel the running job, no done/found pulse
//   core_init/next      one-cycle command pulses, core_block stable with them
//   core_ready/digest*  engine status and result
//   found_*             hit pulse plus held nonce/hash of the last hit
//   done, done_found    job-end pulse and "any hit this job" flag
//   busy, hash_count    activity flag and saturating count of checked nonces
module miner_nonce_sched #(
    parameter logic STOP_ON_FIRST = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [607:0] job_header,
    input  logic [31:0]  job_nonce_start,
    input  logic [31:0]  job_nonce_end,
    input  logic [255:0] job_target,
    input  logic         abort,
    output logic         core_init,
    output logic         core_next,
    output logic [511:0] core_block,
    input  logic         core_ready,
    input  logic [255:0] core_digest,
    input  logic         core_digest_valid,
    output logic         found_valid,
    output logic [31:0]  found_nonce,
    output logic [255:0] found_hash,
    output logic         done,
    output logic         done_found,
    output logic         busy,
    output logic [31:0]  hash_count
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        H1_ISSUE = 4'd1,
        H1_WAIT  = 4'd2,
        H2_ISSUE = 4'd3,
        H2_WAIT  = 4'd4,
        H3_ISSUE = 4'd5,
        H3_WAIT  = 4'd6,
        CHECK    = 4'd7,
        DONE     = 4'd8
    } state_t;

    state_t         state_r;
    logic [607:0]   header_r;
    logic [31:0]    nonce_r;
    logic [31:0]    nonce_end_r;
    logic [255:0]   target_r;
    logic [255:0]   digest_r;
    logic           guard_r;

    logic [31:0]    nonce_le_s;
    logic [511:0]   block_s;
    logic [255:0]   hash_le_s;
    logic           hit_s;

    // Digest byte k (counting from the H0 end) lands in result byte k (LSB end).
    function automatic logic [255:0] byte_reverse_256(input logic [255:0] d);
        logic [255:0] r;
        r = 256'd0;
        for (int k = 0; k < 32; k++) begin
            r[8*k +: 8] = d[255-8*k -: 8];
        end
        return r;
    endfunction

    // Block selection for the pending command, plus the hit test on the last digest.
    always_comb begin
        nonce_le_s = {nonce_r[7:0], nonce_r[15:8], nonce_r[23:16], nonce_r[31:24]};
        case (state_r)
            H1_ISSUE: block_s = header_r[607:96];
            H2_ISSUE: block_s = {header_r[95:0], nonce_le_s, 8'h80, 312'd0, 64'd640};
            H3_ISSUE: block_s = {digest_r, 8'h80, 184'd0, 64'd256};
            default:  block_s = 512'd0;
        endcase
        hash_le_s = byte_reverse_256(digest_r);
        hit_s     = (hash_le_s <= target_r);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            header_r    <= 608'd0;
            nonce_r     <= 32'd0;
            nonce_end_r <= 32'd0;
            target_r    <= 256'd0;
            digest_r    <= 256'd0;
            guard_r     <= 1'b0;
            job_ready   <= 1'b1;
            core_init   <= 1'b0;
            core_next   <= 1'b0;
            core_block  <= 512'd0;
            found_valid <= 1'b0;
            found_nonce <= 32'd0;
            found_hash  <= 256'd0;
            done        <= 1'b0;
            done_found  <= 1'b0;
            busy        <= 1'b0;
            hash_count  <= 32'd0;
        end else begin
            // Pulses default low so each lasts exactly one cycle.
            core_init   <= 1'b0;
            core_next   <= 1'b0;
            found_valid <= 1'b0;
            done        <= 1'b0;
            if ((state_r != IDLE) && abort) begin
                // Any command already issued is left to finish in the core;
                // the next job's H1_ISSUE waits for core_ready.
                state_r   <= IDLE;
                guard_r   <= 1'b0;
                job_ready <= 1'b1;
                busy      <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (job_valid && job_ready) begin
                            header_r    <= job_header;
                            nonce_r     <= job_nonce_start;
                            nonce_end_r <= job_nonce_end;
                            target_r    <= job_target;
                            hash_count  <= 32'd0;
                            done_found  <= 1'b0;
                            job_ready   <= 1'b0;
                            busy        <= 1'b1;
                            state_r     <= H1_ISSUE;
                        end
                    end
                    H1_ISSUE, H2_ISSUE, H3_ISSUE: begin
                        if (core_ready) begin
                            core_block <= block_s;
                            guard_r    <= 1'b1;
                            if (state_r == H2_ISSUE) begin
                                core_next <= 1'b1;
                                state_r   <= H2_WAIT;
                            end else if (state_r == H1_ISSUE) begin
                                core_init <= 1'b1;
                                state_r   <= H1_WAIT;
                            end else begin
                                core_init <= 1'b1;
                                state_r   <= H3_WAIT;
                            end
                        end
                    end
                    H1_WAIT, H2_WAIT, H3_WAIT: begin
                        // The core still shows the previous ready/valid during the
                        // pulse cycle, so the first wait cycle is skipped.
                        if (guard_r) begin
                            guard_r <= 1'b0;
                        end else if (core_ready && core_digest_valid) begin
                            if (state_r == H1_WAIT) begin
                                state_r <= H2_ISSUE;
                            end else if (state_r == H2_WAIT) begin
                                digest_r <= core_digest;
                                state_r  <= H3_ISSUE;
                            end else begin
                                digest_r <= core_digest;
                                state_r  <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (hash_count != 32'hFFFF_FFFF) begin
                            hash_count <= hash_count + 32'd1;
                        end
                        if (hit_s) begin
                            found_valid <= 1'b1;
                            found_nonce <= nonce_r;
                            found_hash  <= hash_le_s;
                            done_found  <= 1'b1;
                        end
                        if ((hit_s && STOP_ON_FIRST) || (nonce_r == nonce_end_r)) begin
                            done    <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            nonce_r <= nonce_r + 32'd1;
                            state_r <= H1_ISSUE;
                        end
                    end
                    DONE: begin
                        job_ready <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end
                    default: begin
                        job_ready <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_miner_nonce_sched.sv
// Bench for miner_nonce_sched: two instances (stop-on-first and full scan),
// each attached to a behavioural SHA-256 engine with variable latency.
// Expected results come from a reference double-SHA-256 of the 80-byte header.
module tb_miner_nonce_sched;

    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [63:0][31:0] KC = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [607:0] GEN_HDR = {32'h01000000, 256'd0,
        256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
        32'h29ab5f49, 32'hffff001d};
    localparam logic [255:0] GEN_TGT = {48'h00000000FFFF, 208'd0};
    localparam logic [255:0] GEN_HASH = 256'h000000000019D6689C085AE165831E934FF763AE46A2A6C172B3F1B60A8CE26F;

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   job_valid_v;
    logic [1:0]   job_ready_v;
    logic [607:0] job_header;
    logic [31:0]  job_nonce_start;
    logic [31:0]  job_nonce_end;
    logic [255:0] job_target;
    logic [1:0]   abort_v;
    logic [1:0]   core_init_v;
    logic [1:0]   core_next_v;
    logic [511:0] core_block_a [2];
    logic [1:0]   core_ready_v = 2'b11;
    logic [1:0]   core_valid_v = 2'b00;
    logic [255:0] core_digest_a [2] = '{256'd0, 256'd0};
    logic [1:0]   found_valid_v;
    logic [31:0]  found_nonce_a [2];
    logic [255:0] found_hash_a [2];
    logic [1:0]   done_v;
    logic [1:0]   done_found_v;
    logic [1:0]   busy_v;
    logic [31:0]  hash_count_a [2];

    logic [255:0] core_h [2] = '{256'd0, 256'd0};
    int           core_cnt [2] = '{0, 0};
    int           core_lat = 2;
    int           found_cnt [2] = '{0, 0};
    int           done_cnt [2] = '{0, 0};
    bit           cmd_log [$];
    logic [31:0]  nonce_log [$];

    int           tests_run = 0;
    int           tests_failed = 0;
    logic [31:0]  exp_fn [2];
    logic [255:0] exp_fh [2];

    always #5 clock = ~clock;

    miner_nonce_sched #(.STOP_ON_FIRST(1'b1)) dut0 (
        .clock(clock), .reset(reset),
        .job_valid(job_valid_v[0]), .job_ready(job_ready_v[0]),
        .job_header(job_header), .job_nonce_start(job_nonce_start),
        .job_nonce_end(job_nonce_end), .job_target(job_target), .abort(abort_v[0]),
        .core_init(core_init_v[0]), .core_next(core_next_v[0]), .core_block(core_block_a[0]),
        .core_ready(core_ready_v[0]), .core_digest(core_digest_a[0]),
        .core_digest_valid(core_valid_v[0]),
        .found_valid(found_valid_v[0]), .found_nonce(found_nonce_a[0]), .found_hash(found_hash_a[0]),
        .done(done_v[0]), .done_found(done_found_v[0]), .busy(busy_v[0]), .hash_count(hash_count_a[0]));

    miner_nonce_sched #(.STOP_ON_FIRST(1'b0)) dut1 (
        .clock(clock), .reset(reset),
        .job_valid(job_valid_v[1]), .job_ready(job_ready_v[1]),
        .job_header(job_header), .job_nonce_start(job_nonce_start),
        .job_nonce_end(job_nonce_end), .job_target(job_target), .abort(abort_v[1]),
        .core_init(core_init_v[1]), .core_next(core_next_v[1]), .core_block(core_block_a[1]),
        .core_ready(core_ready_v[1]), .core_digest(core_digest_a[1]),
        .core_digest_valid(core_valid_v[1]),
        .found_valid(found_valid_v[1]), .found_nonce(found_nonce_a[1]), .found_hash(found_hash_a[1]),
        .done(done_v[1]), .done_found(done_found_v[1]), .busy(busy_v[1]), .hash_count(hash_count_a[1]));

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One SHA-256 compression round set.
    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KC[63-t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // Reference: SHA256(SHA256(80-byte header with little-endian nonce)), shown byte-reversed.
    function automatic logic [255:0] ref_hash_le(input logic [607:0] hdr, input logic [31:0] nonce);
        logic [639:0]  msg;
        logic [1023:0] p1;
        logic [511:0]  p2;
        logic [255:0]  d;
        logic [255:0]  r;
        msg = {hdr, nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24]};
        p1  = {msg, 1'b1, 319'd0, 64'd640};
        d   = sha_compress(sha_compress(IV, p1[1023:512]), p1[511:0]);
        p2  = {d, 1'b1, 191'd0, 64'd256};
        d   = sha_compress(IV, p2);
        for (int k = 0; k < 32; k++) r[8*k +: 8] = d[255-8*k -: 8];
        return r;
    endfunction

    // Behavioural engines: accept a pulse only when idle, answer after core_lat+1 cycles.
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (core_cnt[i] > 0) begin
                core_cnt[i] <= core_cnt[i] - 1;
                if (core_cnt[i] == 1) begin
                    core_ready_v[i]  <= 1'b1;
                    core_valid_v[i]  <= 1'b1;
                    core_digest_a[i] <= core_h[i];
                end
            end else if (core_ready_v[i] && (core_init_v[i] || core_next_v[i])) begin
                core_h[i]       <= sha_compress(core_init_v[i] ? IV : core_h[i], core_block_a[i]);
                core_ready_v[i] <= 1'b0;
                core_valid_v[i] <= 1'b0;
                core_cnt[i]     <= core_lat;
            end
        end
    end

    // Pulse monitor.
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (found_valid_v[i]) found_cnt[i] <= found_cnt[i] + 1;
            if (done_v[i]) done_cnt[i] <= done_cnt[i] + 1;
        end
        if (core_init_v[0]) cmd_log.push_back(1'b0);
        if (core_next_v[0]) begin
            cmd_log.push_back(1'b1);
            nonce_log.push_back(core_block_a[0][415:384]);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input int inst, input logic [607:0] hdr, input logic [31:0] s,
                           input logic [31:0] e, input logic [255:0] tgt);
        @(negedge clock);
        job_header = hdr; job_nonce_start = s; job_nonce_end = e; job_target = tgt;
        job_valid_v[inst] = 1'b1;
        @(negedge clock);
        job_valid_v = 2'b00;
    endtask

    task automatic wait_done(input int inst, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (done_v[inst]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    // Run one job and compare every result against the reference scan.
    task automatic do_job(input int inst, input string tag, input logic [607:0] hdr,
                          input logic [31:0] s, input logic [31:0] e, input logic [255:0] tgt);
        logic [31:0]  n;
        logic [255:0] h;
        int           cnt, hits, f0;
        bit           ok;
        n = s; cnt = 0; hits = 0;
        for (int g = 0; g < 64; g++) begin
            h = ref_hash_le(hdr, n);
            cnt++;
            if (h <= tgt) begin
                hits++;
                exp_fn[inst] = n;
                exp_fh[inst] = h;
            end
            if (((h <= tgt) && (inst == 0)) || (n == e)) break;
            n = n + 32'd1;
        end
        f0 = found_cnt[inst];
        run_job(inst, hdr, s, e, tgt);
        wait_done(inst, ok);
        check({tag, "_done"}, 512'(ok), 512'd1);
        check({tag, "_hash_count"}, 512'(hash_count_a[inst]), 512'(cnt));
        check({tag, "_done_found"}, 512'(done_found_v[inst]), 512'(hits > 0));
        check({tag, "_found_nonce"}, 512'(found_nonce_a[inst]), 512'(exp_fn[inst]));
        check({tag, "_found_hash"}, 512'(found_hash_a[inst]), 512'(exp_fh[inst]));
        @(negedge clock);
        check({tag, "_found_pulses"}, 512'(found_cnt[inst] - f0), 512'(hits));
        check({tag, "_job_ready"}, 512'(job_ready_v[inst]), 512'd1);
    endtask

    initial begin
        int           lb, nb, d0, f0;
        bit           ok, seen_next;
        logic [14:0]  pat_obs;
        logic [14:0]  pat_exp;
        logic [607:0] rh;
        logic [31:0]  rs;
        logic [7:0]   tb8;

        reset = 1'b1; job_valid_v = 2'b00; abort_v = 2'b00;
        job_header = 608'd0; job_nonce_start = 32'd0; job_nonce_end = 32'd0; job_target = 256'd0;
        exp_fn = '{32'd0, 32'd0}; exp_fh = '{256'd0, 256'd0};
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_job_ready", 512'(job_ready_v), 512'd3);
        check("rst_busy", 512'(busy_v), 512'd0);
        check("rst_cmd", 512'({core_init_v, core_next_v}), 512'd0);
        check("rst_block", core_block_a[0], 512'd0);
        check("rst_found", 512'({found_valid_v, found_nonce_a[0], found_hash_a[0]}), 512'd0);
        check("rst_done", 512'({done_v, done_found_v, hash_count_a[0]}), 512'd0);

        // Genesis block, stop on first hit.
        core_lat = 3;
        do_job(0, "genesis", GEN_HDR, 32'h7C2BAC1A, 32'h7C2BAC1F, GEN_TGT);
        check("genesis_nonce_const", 512'(found_nonce_a[0]), 512'(32'h7C2BAC1D));
        check("genesis_hash_const", 512'(found_hash_a[0]), 512'(GEN_HASH));
        check("genesis_count_const", 512'(hash_count_a[0]), 512'd4);

        // Unreachable target: 5 nonces, command order init/next/init.
        lb = cmd_log.size();
        do_job(0, "zero_tgt", GEN_HDR, 32'd0, 32'd4, 256'd0);
        check("zero_tgt_cmds", 512'(cmd_log.size() - lb), 512'd15);
        for (int i = 0; i < 15; i++) begin
            pat_obs[i] = (lb + i < cmd_log.size()) ? cmd_log[lb + i] : 1'b0;
            pat_exp[i] = ((i % 3) == 1);
        end
        check("zero_tgt_order", 512'(pat_obs), 512'(pat_exp));

        // Wrap through 0xFFFFFFFF.
        core_lat = 1;
        nb = nonce_log.size();
        do_job(0, "wrap", GEN_HDR, 32'hFFFFFFFE, 32'h00000001, 256'd0);
        check("wrap_nexts", 512'(nonce_log.size() - nb), 512'd4);
        check("wrap_n0", 512'(nonce_log[nb]), 512'(32'hFEFFFFFF));
        check("wrap_n1", 512'(nonce_log[nb + 1]), 512'(32'hFFFFFFFF));
        check("wrap_n2", 512'(nonce_log[nb + 2]), 512'(32'h00000000));
        check("wrap_n3", 512'(nonce_log[nb + 3]), 512'(32'h01000000));

        // Every hash hits.
        do_job(0, "ones_stop", GEN_HDR, 32'd10, 32'd12, {256{1'b1}});
        check("ones_stop_nonce", 512'(found_nonce_a[0]), 512'd10);
        check("ones_stop_count", 512'(hash_count_a[0]), 512'd1);
        f0 = found_cnt[1];
        do_job(1, "ones_all", GEN_HDR, 32'd10, 32'd12, {256{1'b1}});
        check("ones_all_pulses", 512'(found_cnt[1] - f0), 512'd3);
        check("ones_all_count", 512'(hash_count_a[1]), 512'd3);
        check("ones_all_nonce", 512'(found_nonce_a[1]), 512'd12);

        // Random headers, ranges, targets and latencies.
        for (int r = 0; r < 8; r++) begin
            for (int w = 0; w < 19; w++) rh[32*w +: 32] = $urandom();
            rs  = $urandom();
            tb8 = 8'($urandom_range(0, 48));
            core_lat = $urandom_range(1, 4);
            do_job(r % 2, "rand", rh, rs, rs + 32'($urandom_range(0, 3)), {tb8, {248{1'b1}}});
        end

        // Abort in H2_WAIT; next job must wait for the still-busy core.
        core_lat = 8;
        run_job(0, GEN_HDR, 32'd0, 32'd100, 256'd0);
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clock);
            if (core_next_v[0]) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_reach_h2", 512'(ok), 512'd1);
        d0 = done_cnt[0];
        abort_v[0] = 1'b1;
        @(negedge clock);
        abort_v[0] = 1'b0;
        check("abort_idle", 512'({job_ready_v[0], busy_v[0]}), 512'(2'b10));
        @(negedge clock);
        check("abort_no_done", 512'(done_cnt[0] - d0), 512'd0);
        do_job(0, "after_abort", GEN_HDR, 32'h7C2BAC1A, 32'h7C2BAC1F, GEN_TGT);
        check("after_abort_nonce", 512'(found_nonce_a[0]), 512'(32'h7C2BAC1D));

        // Reset during H3_WAIT.
        run_job(0, GEN_HDR, 32'd0, 32'd100, 256'd0);
        ok = 1'b0; seen_next = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clock);
            if (core_next_v[0]) begin
                seen_next = 1'b1;
            end else if (seen_next && core_init_v[0]) begin
                ok = 1'b1;
                break;
            end
        end
        check("reset_reach_h3", 512'(ok), 512'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_fn = '{32'd0, 32'd0}; exp_fh = '{256'd0, 256'd0};
        check("midrst_ready_busy", 512'({job_ready_v[0], busy_v[0]}), 512'(2'b10));
        check("midrst_cmd", 512'({core_init_v[0], core_next_v[0], core_block_a[0]}), 512'd0);
        check("midrst_found", 512'({found_valid_v[0], found_nonce_a[0], found_hash_a[0]}), 512'd0);
        check("midrst_done", 512'({done_v[0], done_found_v[0], hash_count_a[0]}), 512'd0);
        do_job(0, "after_reset", GEN_HDR, 32'h7C2BAC1A, 32'h7C2BAC1F, GEN_TGT);
        check("after_reset_hash", 512'(found_hash_a[0]), 512'(GEN_HASH));
        check("after_reset_count", 512'(hash_count_a[0]), 512'd4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
